// File: rtl/stream_bitswap_permutation.sv
// Streaming address-bit-swap permutation for inter-stage NTT reordering.
// A frame of N_POINTS elements arrives as N_POINTS/INPUT_PER_CYCLE beats.
// It is written into one of two ping-pong banks in natural order.
// It is read back with two address bits exchanged, chosen per frame.
module stream_bitswap_permutation #(
    parameter int DATA_WIDTH_PER_INPUT = 28,
    parameter int INPUT_PER_CYCLE      = 64,
    parameter int N_POINTS             = 1024
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_start,
    input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] inData,
    input  logic [$clog2($clog2(N_POINTS))-1:0]             cfg_bit_a,
    input  logic [$clog2($clog2(N_POINTS))-1:0]             cfg_bit_b,
    output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] outData,
    output logic                                            out_start,
    output logic                                            out_valid,
    output logic                                            cfg_err
);

    localparam int W      = DATA_WIDTH_PER_INPUT;
    localparam int P      = INPUT_PER_CYCLE;
    localparam int N      = N_POINTS;
    localparam int LOG_N  = $clog2(N);
    localparam int LOG_P  = $clog2(P);
    localparam int CYCLES = N / P;
    localparam int SELW   = $clog2(LOG_N);
    localparam int LOG_C  = LOG_N - LOG_P;

    localparam logic [LOG_C-1:0] LAST_BEAT = LOG_C'(CYCLES - 1);

    // Exchange bits a and b of a global element index.
    function automatic logic [LOG_N-1:0] swap_bits(input logic [LOG_N-1:0] j,
                                                   input logic [SELW-1:0]  a,
                                                   input logic [SELW-1:0]  b);
        logic [LOG_N-1:0] r;
        r    = j;
        r[a] = j[b];
        r[b] = j[a];
        return r;
    endfunction

    // Two banks of N elements, indexed by global element index.
    logic [W-1:0] mem [2][N];

    // Write sequencer state.
    logic             wr_active;
    logic [LOG_C-1:0] wr_cnt;
    logic             wr_bank;

    // Read sequencer state.
    logic             rd_active;
    logic [LOG_C-1:0] rd_cnt;
    logic             rd_bank;

    // Per-bank occupancy and latched swap configuration.
    logic [1:0]           bank_full;
    logic [1:0][SELW-1:0] cfg_a_q;
    logic [1:0][SELW-1:0] cfg_b_q;

    logic             cfg_illegal;
    logic             wr_en;
    logic [LOG_C-1:0] wr_beat;
    logic             rd_go;
    logic [LOG_C-1:0] rd_beat;
    logic [P*W-1:0]   rd_word;

    // An in_start always writes beat 0, even when it aborts a frame in progress.
    assign cfg_illegal = (int'(cfg_bit_a) >= LOG_N) || (int'(cfg_bit_b) >= LOG_N);
    assign wr_en       = !rst && (in_start || wr_active);
    assign wr_beat     = in_start ? '0 : wr_cnt;
    // Reading starts as soon as the read-side bank is full and continues without gaps.
    assign rd_go       = !rst && (rd_active || bank_full[rd_bank]);
    assign rd_beat     = rd_active ? rd_cnt : '0;

    // Bank write: P lanes land at consecutive global indices of the current beat.
    // NOTE: the storage array carries no reset; occupancy flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < P; l++) begin
                mem[wr_bank][{wr_beat, LOG_P'(l)}] <= inData[l*W +: W];
            end
        end
    end

    // Bank read: each output lane fetches the element at the swapped index.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_word = '0;
        for (int l = 0; l < P; l++) begin
            rd_word[l*W +: W] = mem[rd_bank][swap_bits({rd_beat, LOG_P'(l)},
                                                       cfg_a_q[rd_bank],
                                                       cfg_b_q[rd_bank])];
        end
    end

    // Write and read sequencers, bank handover and registered outputs.
    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_active <= 1'b0;
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_active <= 1'b0;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            bank_full <= '0;
            cfg_a_q   <= '0;
            cfg_b_q   <= '0;
            outData   <= '0;
            out_start <= 1'b0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= in_start && cfg_illegal;

            // Read side: release the bank after its last beat.
            if (rd_active) begin
                if (rd_cnt == LAST_BEAT) begin
                    rd_active          <= 1'b0;
                    rd_cnt             <= '0;
                    rd_bank            <= ~rd_bank;
                    bank_full[rd_bank] <= 1'b0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end else if (bank_full[rd_bank]) begin
                rd_active <= 1'b1;
                rd_cnt    <= LOG_C'(1);
            end

            // Write side: a new start restarts beat 0 in the same bank.
            if (in_start) begin
                wr_active        <= 1'b1;
                wr_cnt           <= LOG_C'(1);
                cfg_a_q[wr_bank] <= cfg_illegal ? '0 : cfg_bit_a;
                cfg_b_q[wr_bank] <= cfg_illegal ? '0 : cfg_bit_b;
            end else if (wr_active) begin
                if (wr_cnt == LAST_BEAT) begin
                    wr_active          <= 1'b0;
                    wr_cnt             <= '0;
                    wr_bank            <= ~wr_bank;
                    bank_full[wr_bank] <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end

            out_valid <= rd_go;
            out_start <= rd_go && !rd_active;
            outData   <= rd_go ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_stream_bitswap_permutation.sv
// Self-checking bench for stream_bitswap_permutation at default parameters.
// Completed input frames are pushed to a scoreboard and popped beat by beat.
module tb_stream_bitswap_permutation;

    localparam int W      = 28;
    localparam int P      = 64;
    localparam int N      = 1024;
    localparam int LOG_N  = 10;
    localparam int CYCLES = N / P;
    localparam int SELW   = 4;
    localparam int PW     = P * W;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_start;
    logic [PW-1:0]   inData;
    logic [SELW-1:0] cfg_bit_a;
    logic [SELW-1:0] cfg_bit_b;
    logic [PW-1:0]   outData;
    logic            out_start;
    logic            out_valid;
    logic            cfg_err;

    stream_bitswap_permutation #(
        .DATA_WIDTH_PER_INPUT(W),
        .INPUT_PER_CYCLE     (P),
        .N_POINTS            (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_start (in_start),
        .inData   (inData),
        .cfg_bit_a(cfg_bit_a),
        .cfg_bit_b(cfg_bit_b),
        .outData  (outData),
        .out_start(out_start),
        .out_valid(out_valid),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    // Cycle number: in_start driven during cycle k is sampled at the edge ending it.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int out_cyc;
        int off;
        int a;
        int b;
    } frame_t;

    frame_t sb[$];

    int drv_beat = -1;
    int drv_off;
    int drv_a;
    int drv_b;
    int drv_t0;
    int err_cyc  = -1;

    logic          e_st;
    logic          e_vl;
    logic          e_err;
    logic [PW-1:0] e_data;
    int            lane;

    // Reference permutation: output index j reads input index j with bits a and b exchanged.
    function automatic logic [W-1:0] ref_value(input int j, input int a, input int b, input int off);
        int ba;
        int bb;
        int src;
        if (a >= LOG_N || b >= LOG_N) begin
            a = 0;
            b = 0;
        end
        ba  = (j >> a) & 1;
        bb  = (j >> b) & 1;
        src = (j & ~((1 << a) | (1 << b))) | (bb << a) | (ba << b);
        return W'(src + off);
    endfunction

    // Expected outputs for the current cycle; retires a frame after its last beat.
    function automatic void sb_expect(output logic st, output logic vl, output logic err,
                                      output logic [PW-1:0] data);
        int beat;
        st   = 1'b0;
        vl   = 1'b0;
        err  = (cyc == err_cyc);
        data = '0;
        if (sb.size() > 0 && cyc >= sb[0].out_cyc) begin
            beat = cyc - sb[0].out_cyc;
            vl   = 1'b1;
            st   = (beat == 0);
            for (int l = 0; l < P; l++)
                data[l*W +: W] = ref_value(beat*P + l, sb[0].a, sb[0].b, sb[0].off);
            if (beat == CYCLES - 1) void'(sb.pop_front());
        end
    endfunction

    function automatic int first_diff(input logic [PW-1:0] x, input logic [PW-1:0] y);
        for (int l = 0; l < P; l++)
            if (x[l*W +: W] !== y[l*W +: W]) return l;
        return 0;
    endfunction

    // Drive one input cycle; a frame enters the scoreboard once its last beat is sent.
    task automatic drive_cycle(input bit start, input int off, input int a, input int b);
        in_start  = start;
        cfg_bit_a = SELW'($urandom);
        cfg_bit_b = SELW'($urandom);
        if (start) begin
            drv_beat  = 0;
            drv_off   = off;
            drv_a     = a;
            drv_b     = b;
            drv_t0    = cyc;
            cfg_bit_a = SELW'(a);
            cfg_bit_b = SELW'(b);
            if (a >= LOG_N || b >= LOG_N) err_cyc = cyc + 1;
        end else if (drv_beat >= 0 && drv_beat < CYCLES - 1) begin
            drv_beat++;
        end else begin
            drv_beat = -1;
        end
        if (drv_beat >= 0) begin
            for (int l = 0; l < P; l++) inData[l*W +: W] = W'(drv_beat*P + l + drv_off);
            if (drv_beat == CYCLES - 1)
                sb.push_back('{out_cyc: drv_t0 + CYCLES + 1, off: drv_off, a: drv_a, b: drv_b});
        end else begin
            for (int l = 0; l < P; l++) inData[l*W +: W] = W'($urandom);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            in_start  = (k == 1);
            cfg_bit_a = 4'd12;
            cfg_bit_b = 4'd1;
            for (int l = 0; l < P; l++) inData[l*W +: W] = W'($urandom);
            @(negedge clk);
            if (k >= 1) begin
                total++;
                if ({out_start, out_valid, cfg_err} !== 3'b000 || outData !== '0) begin
                    bad++;
                    $display("FAIL reset_state cyc=%0d start/valid/err=%b%b%b data_zero=%b required 0000 and 1",
                             cyc, out_start, out_valid, cfg_err, outData === '0);
                end
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // The in_start seen during reset must leave no frame behind.
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            drive_cycle(1'b0, 0, 0, 0);
            @(negedge clk);
            sb_expect(e_st, e_vl, e_err, e_data);
            total++;
            if ({out_start, out_valid, cfg_err} !== {e_st, e_vl, e_err}) begin
                bad++;
                $display("FAIL reset_idle_ctl cyc=%0d got start/valid/err=%b%b%b need %b%b%b",
                         cyc, out_start, out_valid, cfg_err, e_st, e_vl, e_err);
            end
            total++;
            if (outData !== e_data) begin
                bad++;
                lane = first_diff(outData, e_data);
                $display("FAIL reset_idle_data cyc=%0d lane=%0d got %0h need %0h",
                         cyc, lane, outData[lane*W +: W], e_data[lane*W +: W]);
            end
        end
    endtask

    task automatic test_single(input string name, input int a, input int b);
        int t0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) t0 = cyc;
            drive_cycle(k == 0, 0, a, b);
            @(negedge clk);
            sb_expect(e_st, e_vl, e_err, e_data);
            total++;
            if ({out_start, out_valid, cfg_err} !== {e_st, e_vl, e_err}) begin
                bad++;
                $display("FAIL %s_ctl cyc=+%0d got start/valid/err=%b%b%b need %b%b%b",
                         name, cyc - t0, out_start, out_valid, cfg_err, e_st, e_vl, e_err);
            end
            total++;
            if (outData !== e_data) begin
                bad++;
                lane = first_diff(outData, e_data);
                $display("FAIL %s_data cyc=+%0d lane=%0d got %0h need %0h",
                         name, cyc - t0, lane, outData[lane*W +: W], e_data[lane*W +: W]);
            end
            if (k == 17) begin
                total++;
                if (out_start !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_latency cyc=+17 got out_start=%b need 1", name, out_start);
                end
            end
        end
    endtask

    task automatic test_swap_0_9();
        int t0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) t0 = cyc;
            drive_cycle(k == 0, 0, 0, 9);
            @(negedge clk);
            sb_expect(e_st, e_vl, e_err, e_data);
            total++;
            if ({out_start, out_valid, cfg_err} !== {e_st, e_vl, e_err}) begin
                bad++;
                $display("FAIL swap09_ctl cyc=+%0d got start/valid/err=%b%b%b need %b%b%b",
                         cyc - t0, out_start, out_valid, cfg_err, e_st, e_vl, e_err);
            end
            total++;
            if (outData !== e_data) begin
                bad++;
                lane = first_diff(outData, e_data);
                $display("FAIL swap09_data cyc=+%0d lane=%0d got %0h need %0h",
                         cyc - t0, lane, outData[lane*W +: W], e_data[lane*W +: W]);
            end
            if (k == 17) begin
                total++;
                if (outData[1*W +: W] !== 28'd512 || outData[0 +: W] !== 28'd0) begin
                    bad++;
                    $display("FAIL swap09_beat0 lane1=%0d lane0=%0d need 512 and 0",
                             outData[1*W +: W], outData[0 +: W]);
                end
            end
            if (k == 25) begin
                total++;
                if (outData[0 +: W] !== 28'd1 || outData[1*W +: W] !== 28'd513) begin
                    bad++;
                    $display("FAIL swap09_beat8 lane0=%0d lane1=%0d need 1 and 513",
                             outData[0 +: W], outData[1*W +: W]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        for (int k = 0; k < 56; k++) begin
            @(posedge clk); #1;
            if (k == 0) t0 = cyc;
            if (k == 16) drive_cycle(1'b1, 0, 3, 7);
            else         drive_cycle(k == 0, 0, 0, 0);
            @(negedge clk);
            sb_expect(e_st, e_vl, e_err, e_data);
            total++;
            if ({out_start, out_valid, cfg_err} !== {e_st, e_vl, e_err}) begin
                bad++;
                $display("FAIL b2b_ctl cyc=+%0d got start/valid/err=%b%b%b need %b%b%b",
                         cyc - t0, out_start, out_valid, cfg_err, e_st, e_vl, e_err);
            end
            total++;
            if (outData !== e_data) begin
                bad++;
                lane = first_diff(outData, e_data);
                $display("FAIL b2b_data cyc=+%0d lane=%0d got %0h need %0h",
                         cyc - t0, lane, outData[lane*W +: W], e_data[lane*W +: W]);
            end
            if (k == 33) begin
                total++;
                if (out_start !== 1'b1 || outData[8*W +: W] !== 28'd128) begin
                    bad++;
                    $display("FAIL b2b_frame_b start=%b lane8=%0d need 1 and 128",
                             out_start, outData[8*W +: W]);
                end
            end
        end
    endtask

    task automatic test_abort();
        int t0;
        int starts = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (k == 0) t0 = cyc;
            if (k == 0)      drive_cycle(1'b1, 28'h0AB0000, 5, 1);
            else if (k == 6) drive_cycle(1'b1, 0, 0, 0);
            else             drive_cycle(1'b0, 0, 0, 0);
            @(negedge clk);
            if (out_start === 1'b1) starts++;
            sb_expect(e_st, e_vl, e_err, e_data);
            total++;
            if ({out_start, out_valid, cfg_err} !== {e_st, e_vl, e_err}) begin
                bad++;
                $display("FAIL abort_ctl cyc=+%0d got start/valid/err=%b%b%b need %b%b%b",
                         cyc - t0, out_start, out_valid, cfg_err, e_st, e_vl, e_err);
            end
            total++;
            if (outData !== e_data) begin
                bad++;
                lane = first_diff(outData, e_data);
                $display("FAIL abort_data cyc=+%0d lane=%0d got %0h need %0h",
                         cyc - t0, lane, outData[lane*W +: W], e_data[lane*W +: W]);
            end
        end
        total++;
        if (starts != 1) begin
            bad++;
            $display("FAIL abort_start_count got %0d need 1", starts);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) t0 = cyc;
            rst = (k == 20);
            drive_cycle(k == 0, 0, 0, 0);
            @(negedge clk);
            sb_expect(e_st, e_vl, e_err, e_data);
            total++;
            if ({out_start, out_valid, cfg_err} !== {e_st, e_vl, e_err}) begin
                bad++;
                $display("FAIL rstmid_ctl cyc=+%0d got start/valid/err=%b%b%b need %b%b%b",
                         cyc - t0, out_start, out_valid, cfg_err, e_st, e_vl, e_err);
            end
            total++;
            if (outData !== e_data) begin
                bad++;
                lane = first_diff(outData, e_data);
                $display("FAIL rstmid_data cyc=+%0d lane=%0d got %0h need %0h",
                         cyc - t0, lane, outData[lane*W +: W], e_data[lane*W +: W]);
            end
            // The rest of the interrupted frame is dropped by the reset.
            if (k == 20) sb.delete();
        end
    endtask

    task automatic test_random_stream();
        int t0;
        int a;
        int b;
        for (int k = 0; k < 72; k++) begin
            @(posedge clk); #1;
            if (k == 0) t0 = cyc;
            a = int'($urandom_range(0, 11));
            b = int'($urandom_range(0, 11));
            drive_cycle(k == 0 || k == 16 || k == 32, int'($urandom_range(0, 1 << 20)), a, b);
            @(negedge clk);
            sb_expect(e_st, e_vl, e_err, e_data);
            total++;
            if ({out_start, out_valid, cfg_err} !== {e_st, e_vl, e_err}) begin
                bad++;
                $display("FAIL random_ctl cyc=+%0d got start/valid/err=%b%b%b need %b%b%b",
                         cyc - t0, out_start, out_valid, cfg_err, e_st, e_vl, e_err);
            end
            total++;
            if (outData !== e_data) begin
                bad++;
                lane = first_diff(outData, e_data);
                $display("FAIL random_data cyc=+%0d lane=%0d got %0h need %0h",
                         cyc - t0, lane, outData[lane*W +: W], e_data[lane*W +: W]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_start  = 1'b0;
        inData    = '0;
        cfg_bit_a = '0;
        cfg_bit_b = '0;
        test_reset();
        test_single("identity", 0, 0);
        test_swap_0_9();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_single("after_reset", 0, 0);
        test_single("illegal_cfg", 12, 2);
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_bitswap_permutation.md
Name: stream_bitswap_permutation

Overview:
- Generic, run-time configurable streaming permutation for inter-stage data reordering in the NTT pipeline.
- Generalises the fixed per-stage permutation blocks: one module serves any stage, with N, lane count and width as parameters.
- A frame is N elements arriving as N/P beats of P lanes. Each frame is reordered by swapping two address bits, chosen per frame.
- Ping-pong buffered, so frames can be streamed back-to-back without gaps.

Parameters:
- DATA_WIDTH_PER_INPUT, 28, width W of one element.
- INPUT_PER_CYCLE, 64, lanes per beat P; power of 2, P ≥ 2.
- N_POINTS, 1024, elements per frame N; power of 2, N ≥ 2P.
- Derived (localparam): LOG_N = clog2(N); LOG_P = clog2(P); CYCLES = N/P; SELW = clog2(LOG_N).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_start, input, 1, single-cycle pulse marking beat 0 of an input frame.
- inData, input, P*W, input beat; lane l occupies [l*W +: W].
- cfg_bit_a, input, SELW, first address bit to swap; sampled only on the in_start cycle.
- cfg_bit_b, input, SELW, second address bit to swap; sampled only on the in_start cycle.
- outData, output, P*W, output beat; same lane packing as inData.
- out_start, output, 1, one-cycle pulse coincident with output beat 0.
- out_valid, output, 1, high on each of the CYCLES output beats.
- cfg_err, output, 1, one-cycle pulse, the cycle after an in_start with an illegal cfg.

Behaviour:
- Addressing:
  - Element global index i = c*P + l, where c is the beat number (0..CYCLES-1) and l is the lane.
  - Output element at global index j = input element at index swap(j, a, b), where swap exchanges bits a and b of j.
  - a == b gives the identity.
  - If a ≥ LOG_N or b ≥ LOG_N: identity is used and cfg_err pulses.
- Input side:
  - The in_start cycle is beat 0. Beats 1..CYCLES-1 are taken unconditionally on the following consecutive cycles; there is no input valid/stall.
  - Data goes into the write bank; cfg is latched per bank.
  - in_start during an unfinished write frame aborts it: the partial bank is discarded, and the new frame restarts at beat 0 of the same bank.
  - in_start asserted on the cycle after beat CYCLES-1 is legal and targets the other bank.
- Bank handover:
  - On the cycle following beat CYCLES-1, the bank is marked full and toggles to the read side.
  - The write pointer moves to the other bank.
- Output side:
  - Read address is generated at cycles CYCLES..2*CYCLES-1 relative to in_start (cycle 0).
  - Outputs are registered, so beats appear at cycles CYCLES+1..2*CYCLES+1-1.
  - Latency from in_start to out_start = CYCLES+1 (17 at defaults).
  - out_valid is high for exactly CYCLES consecutive cycles per frame. Back-to-back frames give continuous out_valid with one out_start per frame.
  - outData = 0 whenever out_valid = 0.
- Bank conflicts:
  - A bank's last read occurs in the cycle before the third frame can write it, so there is no read/write overlap.
  - Bank contents need no reset.
- Reset:
  - Synchronous; outData = 0, out_start = 0, out_valid = 0, cfg_err = 0.
  - Write and read sequencers go idle, both banks are marked empty, and the bank pointer is 0.
  - Reset mid-frame or mid-output: the affected frames are dropped; outputs are 0 from the cycle after rst is sampled.
  - in_start on the same cycle as rst is ignored.
- Implementation:
  - Two banks of N elements of W bits, indexed by global index.
  - Write port: P elements per cycle at indices c*P + l.
  - Read port: P elements at swap(c*P + l).

Test Plan:
(All cases use defaults. Input stimulus: beat c, lane j = c*64 + j.)
- Identity: a = b = 0, in_start at cycle 0 → out_start at cycle 17; beat c, lane j = c*64 + j; out_valid high for cycles 17..32 only.
- Swap bits 0 and 9, a = 0, b = 9 → beat 0, lane 1 = 512; beat 8, lane 0 = 1; beat 8, lane 1 = 513; beat 0, lane 0 = 0.
- Back-to-back: frame A (identity) at cycle 0, frame B at cycle 16 with a = 3, b = 7 → out_start at 17 and 33; out_valid continuous over 17..48; B beat 0, lane 8 = 128.
- Abort: in_start at 0, second in_start at 6 → exactly one out_start, at cycle 23; its contents come from the data presented from cycle 6.
- Reset mid-stream: in_start at 0, rst high at cycle 20 → outputs 0 from cycle 21; no further out_valid; a fresh frame after reset behaves as in the identity case.
- Illegal cfg: a = 12, b = 2 → cfg_err at cycle 1; output equals identity.
